axis_adc_decimator: RTL and testbench

//   Boxcar-average decimator directly downstream of the ADC stream stage.

---
 rtl/axis_adc_dec_pkg.sv | 34 +++
 rtl/adc_dec_channel.sv | 42 ++++
 rtl/axis_adc_decimator.sv | 140 ++++++++++++++
 tb/tb_axis_adc_decimator.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_adc_dec_pkg.sv
// Shared constants, state encoding and the shift/saturate helper for the
// boxcar-average ADC decimator.
package axis_adc_dec_pkg;

  localparam int ADC_WIDTH   = 16;
  localparam int CNTR_WIDTH  = 16;
  localparam int ACC_WIDTH   = ADC_WIDTH + CNTR_WIDTH;
  localparam int SHIFT_WIDTH = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(ADC_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2**(ADC_WIDTH-1)));

  // Arithmetic right shift of a block sum, clamped to the signed sample range.
  function automatic logic [ADC_WIDTH-1:0] shift_sat(
    input logic signed [ACC_WIDTH-1:0]   sum,
    input logic        [SHIFT_WIDTH-1:0] shift
  );
    logic signed [ACC_WIDTH-1:0] shifted;
    shifted = sum >>> shift;
    if (shifted > SAT_MAX) begin
      return SAT_MAX[ADC_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[ADC_WIDTH-1:0];
    end else begin
      return shifted[ADC_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/adc_dec_channel.sv
// One decimator channel: running block accumulator, stage-1 block-sum register
// and the combinational shift/saturate that feeds the shared output register.
module adc_dec_channel
  import axis_adc_dec_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_sample_en,
  input  logic                   i_last,
  input  logic [ADC_WIDTH-1:0]   i_sample,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [ADC_WIDTH-1:0]   o_result
);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_stage1;
  logic signed [ACC_WIDTH-1:0] w_sum;

  assign w_sum = r_acc + ACC_WIDTH'($signed(i_sample));

  // NOTE: non-blocking assignments keep every register reading the pre-edge
  // values, so the final sample lands in stage 1 while the accumulator restarts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_stage1 <= '0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_sample_en) begin
        r_acc <= i_last ? '0 : w_sum;
      end
      if (i_last) begin
        r_stage1 <= w_sum;
      end
    end
  end

  assign o_result = shift_sat(r_stage1, i_shift);

endmodule

// File: rtl/axis_adc_decimator.sv
// Boxcar-average decimator for the {chB,chA} ADC stream: block FSM and counter,
// two channel datapaths, AXIS output register with drop-and-flag overrun.
module axis_adc_decimator
  import axis_adc_dec_pkg::*;
(
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cfg_enable,
  input  logic [CNTR_WIDTH-1:0]  cfg_ratio,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                   s_axis_tvalid,
  input  logic [2*ADC_WIDTH-1:0] s_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [2*ADC_WIDTH-1:0] m_axis_tdata,
  output logic                   sts_overrun
);

  state_t                 r_state;
  logic                   r_en_q;
  logic [CNTR_WIDTH-1:0]  r_cnt;
  logic [CNTR_WIDTH-1:0]  r_ratio_q;
  logic [SHIFT_WIDTH-1:0] r_shift_q;
  logic                   r_s1_valid;
  logic [SHIFT_WIDTH-1:0] r_s1_shift;
  logic                   r_tvalid;
  logic [2*ADC_WIDTH-1:0] r_tdata;
  logic                   r_overrun;

  logic [CNTR_WIDTH-1:0]  w_ratio_eff;
  logic                   w_sample_en;
  logic                   w_last;
  logic                   w_en_rise;
  logic [ADC_WIDTH-1:0]   w_res_a;
  logic [ADC_WIDTH-1:0]   w_res_b;

  assign w_ratio_eff = (cfg_ratio == '0) ? CNTR_WIDTH'(1) : cfg_ratio;
  assign w_sample_en = (r_state == ST_ACCUM) && cfg_enable && s_axis_tvalid;
  assign w_last      = w_sample_en && (r_cnt == r_ratio_q - CNTR_WIDTH'(1));
  assign w_en_rise   = cfg_enable && !r_en_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_en_q    <= 1'b0;
      r_cnt     <= '0;
      r_ratio_q <= '0;
      r_shift_q <= '0;
    end else begin
      r_en_q <= cfg_enable;
      case (r_state)
        ST_IDLE: begin
          if (cfg_enable) begin
            r_state   <= ST_ACCUM;
            r_cnt     <= '0;
            r_ratio_q <= w_ratio_eff;
            r_shift_q <= cfg_shift;
          end
        end
        ST_ACCUM: begin
          if (!cfg_enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_last) begin
            // Config sampled on the final edge governs the block that starts next.
            r_cnt     <= '0;
            r_ratio_q <= w_ratio_eff;
            r_shift_q <= cfg_shift;
          end else if (s_axis_tvalid) begin
            r_cnt <= r_cnt + CNTR_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage-1 sums travel with the shift of their own block, not the next one.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s1_valid <= 1'b0;
      r_s1_shift <= '0;
    end else begin
      r_s1_valid <= w_last;
      if (w_last) begin
        r_s1_shift <= r_shift_q;
      end
    end
  end

  adc_dec_channel u_ch_a (
    .i_clk       (aclk),
    .i_rst       (areset),
    .i_clear     (!cfg_enable),
    .i_sample_en (w_sample_en),
    .i_last      (w_last),
    .i_sample    (s_axis_tdata[ADC_WIDTH-1:0]),
    .i_shift     (r_s1_shift),
    .o_result    (w_res_a)
  );

  adc_dec_channel u_ch_b (
    .i_clk       (aclk),
    .i_rst       (areset),
    .i_clear     (!cfg_enable),
    .i_sample_en (w_sample_en),
    .i_last      (w_last),
    .i_sample    (s_axis_tdata[2*ADC_WIDTH-1:ADC_WIDTH]),
    .i_shift     (r_s1_shift),
    .o_result    (w_res_b)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_en_rise) begin
        r_overrun <= 1'b0;
      end
      if (r_s1_valid) begin
        if (!r_tvalid || m_axis_tready) begin
          r_tvalid <= 1'b1;
          r_tdata  <= {w_res_b, w_res_a};
        end else begin
          // A drop on the enable-rise edge still flags: the later assignment wins.
          r_overrun <= 1'b1;
        end
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign sts_overrun   = r_overrun;

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Self-checking bench for axis_adc_decimator: config table, directed corner
// sequences and randomized traffic against a sample-list reference model.
module tb_axis_adc_decimator;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_ratio = '0;
  logic [4:0]  cfg_shift = '0;
  logic        s_axis_tvalid = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        sts_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  axis_adc_decimator dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_enable    (cfg_enable),
    .cfg_ratio     (cfg_ratio),
    .cfg_shift     (cfg_shift),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .sts_overrun   (sts_overrun)
  );

  initial forever #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } beat_t;

  int          edge_n;
  logic        mdl_prev_en;
  int          mdl_ratio;
  int          mdl_shift;
  int          qa[$];
  int          qb[$];
  beat_t       pipe[$];
  logic        mdl_valid;
  logic [31:0] mdl_data;
  logic        mdl_over;

  function automatic logic [15:0] avg16(longint sum, int shift);
    longint r;
    r = sum >>> shift;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic model_reset();
    edge_n      = 0;
    mdl_prev_en = 1'b0;
    mdl_ratio   = 1;
    mdl_shift   = 0;
    qa.delete();
    qb.delete();
    pipe.delete();
    mdl_valid   = 1'b0;
    mdl_data    = '0;
    mdl_over    = 1'b0;
  endtask

  task automatic start_block();
    mdl_ratio = (cfg_ratio == 16'd0) ? 1 : int'(cfg_ratio);
    mdl_shift = int'(cfg_shift);
  endtask

  task automatic model_edge();
    logic   rise;
    logic   dropped;
    beat_t  b;
    longint sa;
    longint sb;
    rise    = cfg_enable && !mdl_prev_en;
    dropped = 1'b0;
    edge_n++;
    if (pipe.size() > 0 && pipe[0].due == edge_n) begin
      b = pipe.pop_front();
      if (mdl_valid && !m_axis_tready) begin
        dropped = 1'b1;
      end else begin
        mdl_valid = 1'b1;
        mdl_data  = b.data;
      end
    end else if (mdl_valid && m_axis_tready) begin
      mdl_valid = 1'b0;
    end
    if (dropped) mdl_over = 1'b1;
    else if (rise) mdl_over = 1'b0;

    if (!cfg_enable) begin
      qa.delete();
      qb.delete();
    end else if (rise) begin
      start_block();
    end else if (s_axis_tvalid) begin
      qa.push_back(int'($signed(s_axis_tdata[15:0])));
      qb.push_back(int'($signed(s_axis_tdata[31:16])));
      if (qa.size() == mdl_ratio) begin
        sa = 0;
        sb = 0;
        foreach (qa[i]) sa += qa[i];
        foreach (qb[i]) sb += qb[i];
        b.data = {avg16(sb, mdl_shift), avg16(sa, mdl_shift)};
        b.due  = edge_n + 1;
        pipe.push_back(b);
        qa.delete();
        qb.delete();
        start_block();
      end
    end
    mdl_prev_en = cfg_enable;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%08h, want 0x%08h", name, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    if (areset) model_reset();
    else model_edge();
    #1;
    check("tvalid", 32'(m_axis_tvalid), 32'(mdl_valid));
    if (mdl_valid) check("tdata", m_axis_tdata, mdl_data);
    check("overrun", 32'(sts_overrun), 32'(mdl_over));
  endtask

  // ---------------- config table ----------------
  typedef struct {
    logic [15:0] ratio;
    logic [4:0]  shift;
    logic [15:0] cha;
    logic [15:0] chb;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] hist[12];
  int          n;
  int          eff;

  initial begin
    vecs[0] = '{16'd4,  5'd2, 16'd100,   16'hFF38, 32'hFF38_0064};
    vecs[1] = '{16'd4,  5'd0, 16'h7FFF,  16'h8000, 32'h8000_7FFF};
    vecs[2] = '{16'd4,  5'd2, 16'h7FFF,  16'h8000, 32'h8000_7FFF};
    vecs[3] = '{16'd0,  5'd0, 16'h1234,  16'hABCD, 32'hABCD_1234};
    vecs[4] = '{16'd1,  5'd3, 16'hFFF8,  16'h0050, 32'h000A_FFFF};
    vecs[5] = '{16'd3,  5'd0, 16'h8000,  16'd20000, 32'h7FFF_8000};
    vecs[6] = '{16'd16, 5'd4, 16'hFFFD,  16'd5,    32'h0005_FFFD};
    vecs[7] = '{16'd2,  5'd1, 16'hFFFF,  16'd1,    32'h0001_FFFF};

    model_reset();
    #2;
    check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset_tdata", m_axis_tdata, 32'd0);
    check("reset_overrun", 32'(sts_overrun), 32'd0);
    tick();
    areset = 1'b0;
    tick();

    // Table: latency from the enable edge and first beat value.
    for (int v = 0; v < 8; v++) begin
      cfg_enable = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1;
      tick();
      tick();
      cfg_ratio    = vecs[v].ratio;
      cfg_shift    = vecs[v].shift;
      s_axis_tdata = {vecs[v].chb, vecs[v].cha};
      cfg_enable   = 1'b1;
      tick();
      eff = (vecs[v].ratio == 16'd0) ? 1 : int'(vecs[v].ratio);
      n = 0;
      do begin
        tick();
        n++;
      end while (!m_axis_tvalid && n < 40);
      check("vec_latency", 32'(n), 32'(eff + 1));
      check("vec_data", m_axis_tdata, vecs[v].exp_data);
      for (int k = 0; k < 2 * eff; k++) tick();
    end

    // Ratio 0: each input reappears on the output one edge after it was taken.
    cfg_enable = 1'b0;
    tick();
    tick();
    cfg_ratio  = 16'd0;
    cfg_shift  = 5'd0;
    cfg_enable = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      hist[k] = $urandom;
      s_axis_tdata = hist[k];
      tick();
      if (k >= 2) check("passthru", m_axis_tdata, hist[k-1]);
    end

    // Ramp with back-pressure: held beat, dropped blocks, bubble-free reload.
    cfg_enable = 1'b0;
    tick();
    tick();
    cfg_ratio     = 16'd2;
    cfg_shift     = 5'd0;
    m_axis_tready = 1'b0;
    cfg_enable    = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      s_axis_tdata  = {16'h0000, 16'(k)};
      m_axis_tready = (k >= 11);
      tick();
      if (k == 3) check("ramp_first", m_axis_tdata, 32'd3);
      if (k == 10) begin
        check("ramp_held", m_axis_tdata, 32'd3);
        check("ramp_overrun", 32'(sts_overrun), 32'd1);
      end
      if (k == 11) check("ramp_next", m_axis_tdata, 32'd19);
    end

    // Partial block discarded on disable; overrun sticky until re-enable.
    cfg_ratio     = 16'd8;
    cfg_shift     = 5'd3;
    m_axis_tready = 1'b1;
    s_axis_tdata  = 32'h4000_4000;
    tick();
    tick();
    for (int k = 0; k < 5; k++) tick();
    cfg_enable = 1'b0;
    tick();
    tick();
    check("dis_overrun_sticky", 32'(sts_overrun), 32'd1);
    check("dis_no_beat", 32'(m_axis_tvalid), 32'd0);
    cfg_enable   = 1'b1;
    s_axis_tdata = '0;
    tick();
    check("reen_overrun_clr", 32'(sts_overrun), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      s_axis_tdata = {16'hFFF8, 16'(i)};
      tick();
      check("reen_no_early", 32'(m_axis_tvalid), 32'd0);
    end
    s_axis_tdata = '0;
    tick();
    check("reen_valid", 32'(m_axis_tvalid), 32'd1);
    check("reen_data", m_axis_tdata, 32'hFFF8_0004);

    // Asynchronous reset mid-block with a held beat and overrun set.
    cfg_enable = 1'b0;
    tick();
    tick();
    cfg_ratio     = 16'd4;
    cfg_shift     = 5'd0;
    m_axis_tready = 1'b0;
    s_axis_tdata  = {16'd7, 16'd5};
    cfg_enable    = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) tick();
    check("rst_pre_overrun", 32'(sts_overrun), 32'd1);
    #3;
    areset = 1'b1;
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_overrun", 32'(sts_overrun), 32'd0);
    tick();
    areset = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_axis_tvalid && n < 40);
    check("post_rst_latency", 32'(n), 32'd5);
    check("post_rst_data", m_axis_tdata, 32'h001C_0014);

    // Randomized traffic against the model.
    cfg_enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = ($urandom_range(0, 9) != 0);
      s_axis_tdata  = $urandom;
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 15) == 0) begin
        cfg_ratio = 16'($urandom_range(0, 5));
        cfg_shift = 5'($urandom_range(0, 4));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
